// File: rtl/wash_cycle_scheduler_if.sv
// rtl/wash_cycle_scheduler_if.sv - user, status and control signals between scheduler and its neighbours
interface wash_cycle_scheduler_if #(
    parameter int TW = 8
);
    logic          start_req;
    logic          normal_sel;
    logic          quick_sel;
    logic          pause;
    logic          abort;
    logic          soap_wash;
    logic          water_wash;
    logic          motor_on;
    logic          drain_valve_on;
    logic          done;
    logic          start;
    logic          normal_wash;
    logic          quick_wash;
    logic          cycle_time_out;
    logic          spin_time_out;
    logic [3:0]    phase;
    logic [TW-1:0] remaining;
    logic          fault;

    modport master (
        output start_req, normal_sel, quick_sel, pause, abort,
        output soap_wash, water_wash, motor_on, drain_valve_on, done,
        input  start, normal_wash, quick_wash, cycle_time_out, spin_time_out,
        input  phase, remaining, fault
    );

    modport slave (
        input  start_req, normal_sel, quick_sel, pause, abort,
        input  soap_wash, water_wash, motor_on, drain_valve_on, done,
        output start, normal_wash, quick_wash, cycle_time_out, spin_time_out,
        output phase, remaining, fault
    );
endinterface

// File: rtl/wash_cycle_scheduler.sv
// rtl/wash_cycle_scheduler.sv - wash/rinse/spin phase sequencer with prescaled timer, watchdog, pause and abort
module wash_cycle_scheduler #(
    parameter int CLK_PER_TICK = 1000,
    parameter int NORMAL_TICKS = 20,
    parameter int QUICK_TICKS  = 8,
    parameter int RINSE_TICKS  = 6,
    parameter int SPIN_TICKS   = 10,
    parameter int WAIT_LIMIT   = 50,
    parameter int TW           = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    wash_cycle_scheduler_if.slave bus
);
    localparam int PW = $clog2(CLK_PER_TICK);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_TICK - 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_ARM        = 4'd1,
        S_WASH       = 4'd2,
        S_WAIT_RINSE = 4'd3,
        S_RINSE      = 4'd4,
        S_WAIT_SPIN  = 4'd5,
        S_SPIN       = 4'd6,
        S_WAIT_DONE  = 4'd7,
        S_FAULT      = 4'd8
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] r_wdog;
    logic          r_start;
    logic          r_normal;
    logic          r_quick;
    logic          r_cto;
    logic          r_sto;
    logic          r_fault;

    logic w_tick;
    logic w_wait;
    logic w_advance;
    logic w_expire;
    logic w_wd_expire;

    assign w_tick      = !bus.pause && (r_presc == PRESC_MAX);
    assign w_expire    = w_tick && (r_timer == TW'(1));
    assign w_wd_expire = w_wait && w_tick && (r_wdog == TW'(WAIT_LIMIT - 1));

    // Status inputs only count in the wait state that expects them.
    always_comb begin
        w_wait    = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            S_ARM:        begin w_wait = 1'b1; w_advance = bus.soap_wash;  end
            S_WAIT_RINSE: begin w_wait = 1'b1; w_advance = bus.water_wash; end
            S_WAIT_SPIN:  begin w_wait = 1'b1; w_advance = bus.motor_on && bus.drain_valve_on; end
            S_WAIT_DONE:  begin w_wait = 1'b1; w_advance = bus.done;       end
            default:      begin w_wait = 1'b0; w_advance = 1'b0;           end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            r_timer  <= '0;
            r_wdog   <= '0;
            r_start  <= 1'b0;
            r_normal <= 1'b0;
            r_quick  <= 1'b0;
            r_cto    <= 1'b0;
            r_sto    <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_cto <= 1'b0;
            r_sto <= 1'b0;
            if (!bus.pause)
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick && r_timer != '0)
                r_timer <= r_timer - 1'b1;
            if (w_tick && w_wait)
                r_wdog <= r_wdog + 1'b1;

            if (bus.abort) begin
                r_state  <= S_IDLE;
                r_start  <= 1'b0;
                r_normal <= 1'b0;
                r_quick  <= 1'b0;
                r_fault  <= 1'b0;
                r_timer  <= '0;
                r_presc  <= '0;
                r_wdog   <= '0;
            end else if (w_wd_expire && !w_advance) begin
                r_state  <= S_FAULT;
                r_start  <= 1'b0;
                r_normal <= 1'b0;
                r_quick  <= 1'b0;
                r_fault  <= 1'b1;
                r_presc  <= '0;
                r_wdog   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start_req && (bus.normal_sel ^ bus.quick_sel)) begin
                            r_state  <= S_ARM;
                            r_start  <= 1'b1;
                            r_normal <= bus.normal_sel;
                            r_quick  <= bus.quick_sel;
                            r_presc  <= '0;
                            r_wdog   <= '0;
                        end
                    end
                    S_ARM: begin
                        if (w_advance) begin
                            r_state <= S_WASH;
                            r_timer <= r_normal ? TW'(NORMAL_TICKS) : TW'(QUICK_TICKS);
                            r_presc <= '0;
                            r_wdog  <= '0;
                        end
                    end
                    S_WASH: begin
                        if (w_expire) begin
                            r_state <= S_WAIT_RINSE;
                            r_cto   <= 1'b1;
                            r_timer <= '0;
                            r_presc <= '0;
                        end
                    end
                    S_WAIT_RINSE: begin
                        if (w_advance) begin
                            r_state <= S_RINSE;
                            r_timer <= TW'(RINSE_TICKS);
                            r_presc <= '0;
                            r_wdog  <= '0;
                        end
                    end
                    S_RINSE: begin
                        if (w_expire) begin
                            r_state <= S_WAIT_SPIN;
                            r_cto   <= 1'b1;
                            r_timer <= '0;
                            r_presc <= '0;
                        end
                    end
                    S_WAIT_SPIN: begin
                        if (w_advance) begin
                            r_state <= S_SPIN;
                            r_timer <= TW'(SPIN_TICKS);
                            r_presc <= '0;
                            r_wdog  <= '0;
                        end
                    end
                    S_SPIN: begin
                        if (w_expire) begin
                            r_state <= S_WAIT_DONE;
                            r_sto   <= 1'b1;
                            r_timer <= '0;
                            r_presc <= '0;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (w_advance) begin
                            r_state  <= S_IDLE;
                            r_start  <= 1'b0;
                            r_normal <= 1'b0;
                            r_quick  <= 1'b0;
                            r_presc  <= '0;
                            r_wdog   <= '0;
                        end
                    end
                    S_FAULT: begin
                        r_state <= S_FAULT;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.start          = r_start;
    assign bus.normal_wash    = r_normal;
    assign bus.quick_wash     = r_quick;
    assign bus.cycle_time_out = r_cto;
    assign bus.spin_time_out  = r_sto;
    assign bus.phase          = r_state;
    assign bus.remaining      = r_timer;
    assign bus.fault          = r_fault;
endmodule

// File: doc/wash_cycle_scheduler.md
# wash_cycle_scheduler

Program sequencer that sits in front of the `washing_machine` controller and drives its start, program-select and timeout inputs. It accepts a user start request with a program choice, then watches the controller's phase outputs. It times the wash, rinse and spin phases with a prescaled tick counter and pulses `cycle_time_out` / `spin_time_out` when each phase expires. A per-wait watchdog, a pause feature and an abort path are included.

## Interface
- `CLK_PER_TICK`, 1000: clocks per timer tick (≥2)
- `NORMAL_TICKS`, 20: wash length for the normal program
- `QUICK_TICKS`, 8: wash length for the quick program
- `RINSE_TICKS`, 6: rinse length
- `SPIN_TICKS`, 10: spin length
- `WAIT_LIMIT`, 50: max ticks spent in any wait state before fault
- `TW`, 8: timer width; every tick parameter must be between 1 and 2^TW-1
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start_req` in 1: user start request (level)
- `normal_sel` in 1: user selects normal program
- `quick_sel` in 1: user selects quick program
- `pause` in 1: freezes prescaler, phase timer and watchdog
- `abort` in 1: synchronous cancel
- `soap_wash`, `water_wash`, `motor_on`, `drain_valve_on`, `done` in 1 each: status from the washing machine
- `start`, `normal_wash`, `quick_wash` out 1 each: driven to the washing machine
- `cycle_time_out`, `spin_time_out` out 1 each: one-clock pulses to the washing machine
- `phase` out 4: current state code
- `remaining` out TW: ticks left in the current timed phase; 0 otherwise
- `fault` out 1: watchdog expired

## Operation
- States and `phase` codes: IDLE=0, ARM=1, WASH=2, WAIT_RINSE=3, RINSE=4, WAIT_SPIN=5, SPIN=6, WAIT_DONE=7, FAULT=8.
- IDLE → ARM when `start_req`=1 and exactly one of `normal_sel`/`quick_sel` is 1. The program is latched at this transition.
  - Both selects high, or neither high: the request is ignored and the block stays in IDLE.
- ARM/WASH/WAIT_RINSE/RINSE/WAIT_SPIN/SPIN/WAIT_DONE: `start`=1 and the latched program line is held at 1.
- ARM → WASH on `soap_wash`=1. The timer loads NORMAL_TICKS or QUICK_TICKS.
- WASH: when the timer hits 0, pulse `cycle_time_out` and go to WAIT_RINSE.
- WAIT_RINSE → RINSE on `water_wash`=1. The timer loads RINSE_TICKS.
- RINSE: when the timer hits 0, pulse `cycle_time_out` and go to WAIT_SPIN.
- WAIT_SPIN → SPIN on `motor_on`=1 and `drain_valve_on`=1. The timer loads SPIN_TICKS.
- SPIN: when the timer hits 0, pulse `spin_time_out` and go to WAIT_DONE.
- WAIT_DONE → IDLE on `done`=1. `start` and the program lines drop in IDLE.
- Watchdog (wait states only: ARM, WAIT_RINSE, WAIT_SPIN, WAIT_DONE):
  - Counts ticks and clears on every state change.
  - Reaching WAIT_LIMIT → FAULT.
  - FAULT: `fault`=1, `start` and program lines low, no timeout pulses. Exit only via `abort` or reset.
- `abort`=1 in any state → IDLE at the next edge, with all outputs low. `abort` has priority over every other transition, including timer expiry in the same cycle.
- `pause`=1: prescaler, phase timer and watchdog hold their values. State transitions triggered by status inputs still occur. A timer-expiry transition cannot occur while paused.
- Status inputs are sampled only in the matching wait state. A `soap_wash` that is already high when ARM is entered advances the FSM on the next edge.

## Timing
- Reset: state IDLE; all outputs 0, `phase`=0, `remaining`=0, prescaler 0.
- Prescaler:
  - Counts 0..CLK_PER_TICK-1 while not paused.
  - A tick fires in the cycle where count = CLK_PER_TICK-1.
  - The prescaler clears on each timer load and on each state change.
- Timer load occurs on the entry edge. `remaining` shows the loaded value in the first cycle of the state.
- Each tick decrements the timer.
- On the edge of the N-th tick, the state advances and the timeout pulse is high for exactly the following clock. With no pause, that is N×CLK_PER_TICK clocks after entry.
- `cycle_time_out` and `spin_time_out` are registered and never both high. Neither is high outside the cycle after expiry.
- Latency from `done`=1 to `start`=0 is one clock. From `abort` to outputs low is one clock.

## Test plan
- Normal run, CLK_PER_TICK=4, NORMAL=3, RINSE=2, SPIN=2:
  - Drive the status sequence in order.
  - Required: `cycle_time_out` pulses exactly 12 clocks after WASH entry and 8 after RINSE entry; `spin_time_out` pulses 8 after SPIN entry.
  - Required: `normal_wash`=1 throughout, then `start`=0 one clock after `done`.
- Quick run, QUICK=1: WASH expiry after 4 clocks; `quick_wash`=1 and `normal_wash`=0 throughout.
- Invalid select: `start_req`=1 with both selects, then with neither → `phase` stays 0 and `start` stays 0.
- Pause in WASH with `remaining`=2 for 10 clocks → `remaining` holds at 2 and expiry is delayed by exactly 10 clocks.
- Watchdog, WAIT_LIMIT=3: hold `water_wash`=0 in WAIT_RINSE → after 12 clocks `phase`=8 and `fault`=1. Then `abort` → `phase`=0 and `fault`=0.
- Abort in the same cycle as SPIN expiry → no `spin_time_out` pulse and `phase`=0. Reset asserted mid-RINSE → all outputs 0 immediately, with no clock edge needed.
